wrf_rsp_drain: RTL

Downstream consumer of the in-order write/read/fence channel in the ASE CCI-P model. Pops one transaction at a time from the channel output through a `read_en`/`valid_out` handshake. Holds each popped transaction for a programmable response latency, then drives it as an Rx response on C0 (reads) or C1 (writes, fences). Collapses multi-line VH write beats (`format=1`) into a single packed write response.

---
 rtl/ase_ccip_pkg.sv | 41 ++++
 rtl/wrf_rsp_drain.sv | 108 ++++++++++
 2 files changed

// File: rtl/ase_ccip_pkg.sv
// Shared CCI-P model types: request/response headers, response type codes and
// the response-drain FSM state encoding.
package ase_ccip_pkg;

  localparam int CCIP_DATA_WIDTH = 512;

  localparam logic [3:0] ASE_RD_RSP      = 4'h0;
  localparam logic [3:0] ASE_WR_RSP      = 4'h1;
  localparam logic [3:0] ASE_WRFENCE_RSP = 4'h4;

  typedef struct packed {
    logic [1:0]  vc;
    logic [1:0]  rsvd;
    logic [1:0]  clen;
    logic [3:0]  reqtype;
    logic [41:0] addr;
    logic [15:0] mdata;
  } TxHdr_t;

  typedef struct packed {
    logic [1:0]  vc_used;
    logic        hitmiss;
    logic        format;
    logic [1:0]  clnum;
    logic [3:0]  resptype;
    logic [15:0] mdata;
  } RxHdr_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DELAY = 2'd2,
    EMIT  = 2'd3
  } rsp_drain_state_t;

  // Multi-line VH write beat that must be collapsed into one response.
  function automatic logic isPackedWrRsp(input RxHdr_t hdr);
    return (hdr.resptype == ASE_WR_RSP) && hdr.format;
  endfunction

endpackage

// File: rtl/wrf_rsp_drain.sv
// Drains the in-order write/read/fence channel one entry at a time, applies a
// programmable response latency and emits Rx responses on C0 (reads) or C1.
module wrf_rsp_drain
  import ase_ccip_pkg::*;
#(
  parameter int COUNT_WIDTH   = 8,
  parameter int RSP_CNT_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [COUNT_WIDTH-1:0]     lat_cfg,
  input  logic                       ch_empty,
  input  logic                       ch_valid,
  input  TxHdr_t                     ch_txhdr,
  input  RxHdr_t                     ch_rxhdr,
  input  logic [CCIP_DATA_WIDTH-1:0] ch_data,
  output logic                       ch_read_en,
  input  logic                       rsp_stall,
  output logic                       c0_valid,
  output logic                       c1_valid,
  output RxHdr_t                     rx_hdr,
  output logic [CCIP_DATA_WIDTH-1:0] rx_data,
  output logic                       busy,
  output logic                       pack_error,
  output logic [RSP_CNT_WIDTH-1:0]   rsp_cnt
);

  localparam logic [COUNT_WIDTH-1:0]   LAT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [RSP_CNT_WIDTH-1:0] CNT_ONE = {{(RSP_CNT_WIDTH-1){1'b0}}, 1'b1};

  rsp_drain_state_t           state_q;
  RxHdr_t                     rx_hdr_q;
  logic [CCIP_DATA_WIDTH-1:0] rx_data_q;
  logic [1:0]                 beat_cnt_q;
  logic [COUNT_WIDTH-1:0]     lat_cnt_q;
  logic [RSP_CNT_WIDTH-1:0]   rsp_cnt_q;
  logic                       pack_error_q;

  logic is_pk_beat;
  logic pk_absorb;
  logic rsp_is_rd;
  logic unused_txhdr;

  assign is_pk_beat   = isPackedWrRsp(ch_rxhdr);
  assign pk_absorb    = is_pk_beat && (beat_cnt_q < ch_rxhdr.clnum);
  assign rsp_is_rd    = (rx_hdr_q.resptype == ASE_RD_RSP);
  assign unused_txhdr = ^ch_txhdr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rx_hdr_q     <= '0;
      rx_data_q    <= '0;
      beat_cnt_q   <= 2'd0;
      lat_cnt_q    <= '0;
      rsp_cnt_q    <= '0;
      pack_error_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!ch_empty) state_q <= WAIT;
        end
        WAIT: begin
          if (!ch_valid) begin
            state_q <= IDLE;
          end else if (pk_absorb) begin
            beat_cnt_q <= beat_cnt_q + 2'd1;
            state_q    <= IDLE;
          end else begin
            rx_hdr_q   <= ch_rxhdr;
            rx_data_q  <= ch_data;
            beat_cnt_q <= 2'd0;
            if (!is_pk_beat && (beat_cnt_q != 2'd0)) pack_error_q <= 1'b1;
            // The capture cycle is the first latency cycle; the counter holds
            // the remaining DELAY cycles.
            if (lat_cfg <= LAT_ONE) begin
              state_q <= EMIT;
            end else begin
              lat_cnt_q <= lat_cfg - LAT_ONE;
              state_q   <= DELAY;
            end
          end
        end
        DELAY: begin
          if (lat_cnt_q == LAT_ONE) state_q <= EMIT;
          else lat_cnt_q <= lat_cnt_q - LAT_ONE;
        end
        EMIT: begin
          if (!rsp_stall) begin
            rsp_cnt_q <= rsp_cnt_q + CNT_ONE;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ch_read_en = rst_n && (state_q == IDLE) && !ch_empty;
  assign c0_valid   = (state_q == EMIT) && rsp_is_rd && !rsp_stall;
  assign c1_valid   = (state_q == EMIT) && !rsp_is_rd && !rsp_stall;
  assign rx_hdr     = rx_hdr_q;
  assign rx_data    = rx_data_q;
  assign busy       = (state_q != IDLE) || (beat_cnt_q != 2'd0);
  assign pack_error = pack_error_q;
  assign rsp_cnt    = rsp_cnt_q;

endmodule
